// File: rtl/gb_dma_pkg.sv
// Shared definitions for the sprite-attribute (OAM) DMA controller.
package gb_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    localparam logic [15:0] OAM_DMA_REG_ADDR = 16'hFF46;

    // Pages $E0-$FF are the echo of work RAM at $C0-$DF.
    localparam logic [7:0] ECHO_BASE_PAGE = 8'hE0;
    localparam logic [7:0] ECHO_OFFSET    = 8'h20;

    localparam int DEFAULT_XFER_LEN    = 160;
    localparam int DEFAULT_BYTE_PERIOD = 4;

    // Folds echo-RAM pages back onto the real work RAM page.
    function automatic logic [7:0] map_src_page(input logic [7:0] page);
        return (page >= ECHO_BASE_PAGE) ? (page - ECHO_OFFSET) : page;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a write to $FF46 copies XFER_LEN bytes from
// {page,$00..} into OAM, one byte every BYTE_PERIOD clocks.
// Optional macro OAM_DMA_BUS_CONFLICT_EN drives cpu_block during the copy;
// without it cpu_block is tied low.
module oam_dma_ctrl
    import gb_dma_pkg::*;
#(
    parameter int BYTE_PERIOD = DEFAULT_BYTE_PERIOD,
    parameter int XFER_LEN    = DEFAULT_XFER_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_sel,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    output logic        dma_rd,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_data,
    output logic        oam_wr,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        active,
    output logic        cpu_block
);

    localparam logic [3:0] LAST_PHASE = 4'(BYTE_PERIOD - 1);
    localparam logic [7:0] LAST_BYTE  = 8'(XFER_LEN - 1);

    dma_state_t state, state_next;
    logic [3:0] phase, phase_next;
    logic [7:0] counter, counter_next;
    logic [7:0] page, page_next;
    logic       wr_prev;
    logic       active_q;
    logic       trigger;
    logic       write_en;
    logic [7:0] src_page;

    // A held CPU write strobe only starts one transfer.
    assign trigger  = cpu_sel & cpu_wr & ~wr_prev;
    assign src_page = map_src_page(page);

    // State, counters, latched page and the registered active flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= 4'd0;
            counter  <= 8'd0;
            page     <= 8'hFF;
            wr_prev  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= phase_next;
            counter  <= counter_next;
            page     <= page_next;
            wr_prev  <= cpu_sel & cpu_wr;
            active_q <= (state_next != IDLE);
        end
    end

    // Sequencing: START delay, then one OAM write at the end of each byte period;
    // a new trigger restarts from START, letting only a final write complete.
    always_comb begin
        state_next   = state;
        phase_next   = phase;
        counter_next = counter;
        page_next    = page;
        write_en     = 1'b0;

        case (state)
            IDLE: begin
            end
            START: begin
                if (phase == LAST_PHASE) begin
                    state_next   = XFER;
                    phase_next   = 4'd0;
                    counter_next = 8'd0;
                end else begin
                    phase_next = phase + 4'd1;
                end
            end
            XFER: begin
                if (phase == LAST_PHASE) begin
                    write_en   = 1'b1;
                    phase_next = 4'd0;
                    if (counter == LAST_BYTE) begin
                        state_next   = IDLE;
                        counter_next = 8'd0;
                    end else begin
                        counter_next = counter + 8'd1;
                    end
                end else begin
                    phase_next = phase + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (trigger) begin
            page_next    = cpu_di;
            state_next   = START;
            phase_next   = 4'd0;
            counter_next = 8'd0;
            write_en     = write_en & (counter == LAST_BYTE);
        end
    end

    assign dma_rd   = (state == XFER);
    assign dma_addr = dma_rd ? {src_page, counter} : 16'h0000;
    assign oam_wr   = write_en;
    assign oam_addr = write_en ? counter : 8'd0;
    assign oam_data = write_en ? dma_data : 8'd0;
    assign active   = active_q;
    assign cpu_do   = page;

`ifdef OAM_DMA_BUS_CONFLICT_EN
    assign cpu_block = (state == XFER);
`else
    assign cpu_block = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl against a timing-rule reference model.
module tb_oam_dma_ctrl;

    localparam int BP       = 4;
    localparam int LEN      = 160;
    localparam int XFER_END = BP + LEN * BP;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_sel;
    logic        cpu_wr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        dma_rd;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;
    logic        oam_wr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        active;
    logic        cpu_block;

    logic [7:0] mem [0:65535];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    // Reference model state: the most recent accepted trigger and reset.
    bit         have_tr = 1'b0;
    int         tr_cyc = 0;
    logic [7:0] tr_page = 8'hFF;
    int         rst_cyc = -1;
    logic       prev_in = 1'b0;

    oam_dma_ctrl #(.BYTE_PERIOD(BP), .XFER_LEN(LEN)) dut (
        .clk(clk),
        .reset(reset),
        .cpu_sel(cpu_sel),
        .cpu_wr(cpu_wr),
        .cpu_di(cpu_di),
        .cpu_do(cpu_do),
        .dma_rd(dma_rd),
        .dma_addr(dma_addr),
        .dma_data(dma_data),
        .oam_wr(oam_wr),
        .oam_addr(oam_addr),
        .oam_data(oam_data),
        .active(active),
        .cpu_block(cpu_block)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous source RAM: data follows the address by one clock.
    always @(posedge clk) dma_data <= mem[dma_addr];

    function automatic logic [7:0] src_of(input logic [7:0] p);
        return (p >= 8'hE0) ? (p - 8'h20) : p;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", tag, cyc, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] page, input int hold);
        cpu_sel = 1'b1;
        cpu_wr  = 1'b1;
        cpu_di  = page;
        step(hold);
        cpu_sel = 1'b0;
        cpu_wr  = 1'b0;
        cpu_di  = 8'($urandom);
    endtask

    // Expected outputs from the trigger-relative timing rules, checked each negedge.
    always @(negedge clk) begin
        bit         live;
        bit         trig;
        int         r;
        int         idx;
        logic       e_act, e_rd, e_wr, e_blk;
        logic [7:0] e_do, sp;
        logic [15:0] e_addr;

        live  = have_tr && (tr_cyc > rst_cyc);
        r     = live ? (cyc - tr_cyc) : 0;
        sp    = src_of(tr_page);
        e_act = live && (r >= 1) && (r <= XFER_END);
        e_rd  = live && (r > BP) && (r <= XFER_END);
        e_wr  = live && (r >= 2 * BP) && ((r % BP) == 0) && (r <= XFER_END);
        idx   = r / BP - 2;
        e_addr = {sp, 8'((r - BP - 1) / BP)};
        e_do  = live ? tr_page : 8'hFF;
`ifdef OAM_DMA_BUS_CONFLICT_EN
        e_blk = e_rd;
`else
        e_blk = 1'b0;
`endif
        trig = !reset && cpu_sel && cpu_wr && !prev_in;
        if (trig && e_wr && (idx != LEN - 1)) e_wr = 1'b0;

        if (cyc > 0) begin
            checkOutput("active", {15'd0, active}, {15'd0, e_act});
            checkOutput("dma_rd", {15'd0, dma_rd}, {15'd0, e_rd});
            checkOutput("oam_wr", {15'd0, oam_wr}, {15'd0, e_wr});
            checkOutput("cpu_block", {15'd0, cpu_block}, {15'd0, e_blk});
            checkOutput("cpu_do", {8'd0, cpu_do}, {8'd0, e_do});
            if (e_rd) checkOutput("dma_addr", dma_addr, e_addr);
            if (e_wr) begin
                checkOutput("oam_addr", {8'd0, oam_addr}, {8'd0, 8'(idx)});
                checkOutput("oam_data", {8'd0, oam_data}, {8'd0, mem[{sp, 8'(idx)}]});
            end
            if (rst_cyc == cyc - 1) begin
                checkOutput("rst_dma_addr", dma_addr, 16'h0000);
                checkOutput("rst_oam_addr", {8'd0, oam_addr}, 16'h0000);
                checkOutput("rst_oam_data", {8'd0, oam_data}, 16'h0000);
            end
        end

        if (reset) rst_cyc = cyc;
        if (trig) begin
            have_tr = 1'b1;
            tr_cyc  = cyc;
            tr_page = cpu_di;
        end
        prev_in = reset ? 1'b0 : (cpu_sel & cpu_wr);
    end

    // Directed scenarios followed by randomized triggers and restarts.
    initial begin
        for (int i = 0; i < 65536; i++) begin
            if (i >= 32'hC000 && i < 32'hE000) mem[i] = 8'(i) ^ 8'h5A;
            else mem[i] = 8'($urandom);
        end
        reset   = 1'b1;
        cpu_sel = 1'b0;
        cpu_wr  = 1'b0;
        cpu_di  = 8'h00;
        step(3);
        reset = 1'b0;
        step(5);

        applyStimulus(8'hC1, 1);
        step(660);
        applyStimulus(8'hE2, 1);
        step(660);
        applyStimulus(8'hD3, 3);
        step(660);

        applyStimulus(8'hC1, 1);
        step(211);
        applyStimulus(8'h80, 1);
        step(660);

        applyStimulus(8'hC1, 1);
        step(408);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(700);

        applyStimulus(8'hC4, 1);
        step(643);
        applyStimulus(8'hF5, 1);
        step(660);

        applyStimulus(8'h12, 1);
        step(2);
        applyStimulus(8'h34, 1);
        step(660);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(8'($urandom), $urandom_range(1, 3));
            step($urandom_range(1, 700));
        end
        step(700);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
